// File: rtl/demux64_collector_pkg.sv
// demux64_pkg: shared widths and FSM state type for the demux64 collector.
// Feature macro used by the collector: DEMUX64_COLLECTOR_PARITY_EN.
package demux64_pkg;

    localparam int WORD_W = 64;
    localparam int IDX_W  = 6;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        PARITY = 2'd1,
        FULL   = 2'd2
    } state_t;

endpackage

// File: rtl/demux64_collector_if.sv
// demux64_collector_if: serial-bit input side and parallel-word output side
// of the collector, bundled together. The collector uses the slave modport;
// the bit producer / word consumer side uses the master modport.
interface demux64_collector_if;
    import demux64_pkg::*;

    logic              clear;
    logic              in_bit;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic              out_perr;

    modport master (
        output clear,
        output in_bit,
        output in_valid,
        input  in_ready,
        input  out_word,
        input  out_valid,
        output out_ready,
        input  out_idx,
        input  out_perr
    );

    modport slave (
        input  clear,
        input  in_bit,
        input  in_valid,
        output in_ready,
        output out_word,
        output out_valid,
        input  out_ready,
        output out_idx,
        output out_perr
    );

endinterface

// File: rtl/demux64_collector_demux8.sv
// demux8: 3-to-8 one-hot decoder with enable; leaf of the 1:64 write-enable tree.
module demux8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] onehot
);

    // one-hot decode of sel, all zeros when disabled
    always_comb begin
        onehot = 8'h00;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux64_collector.sv
// demux64_collector: serial-to-parallel collector. Each accepted bit is
// steered through a two-level 1:64 demux tree into word position out_idx,
// LSB-first. The completed word is offered with a valid/ready handshake.
// Optional even-parity bit after bit 63: define DEMUX64_COLLECTOR_PARITY_EN.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FILL   | accepting data bits, written in place at out_idx
// PARITY | accepting the trailing even-parity bit (parity build only)
// FULL   | word complete, out_valid high, input stalled until out_ready
module demux64_collector
    import demux64_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    demux64_collector_if.slave bus
);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] wr_en;
    logic [7:0]        grp_en;
    logic              in_ready_w;
    logic              accept;
    logic              fill_acc;
    logic              last_bit;
    logic              handshake;
    logic              perr_w;

    assign in_ready_w = (state_q != FULL);
    assign accept     = bus.in_valid && in_ready_w;
    assign fill_acc   = accept && (state_q == FILL);
    assign last_bit   = fill_acc && (idx_q == IDX_W'(WORD_W - 1));
    assign handshake  = (state_q == FULL) && bus.out_ready;

    // first level picks the byte lane, second level picks the bit in it
    demux8 u_dmx_top (
        .sel    (idx_q[5:3]),
        .en     (fill_acc),
        .onehot (grp_en)
    );

    for (genvar g = 0; g < 8; g++) begin : g_leaf
        demux8 u_dmx_leaf (
            .sel    (idx_q[2:0]),
            .en     (grp_en[g]),
            .onehot (wr_en[g*8 +: 8])
        );
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode; clear overrides every other event
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (last_bit) begin
`ifdef DEMUX64_COLLECTOR_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = FULL;
`endif
                    end
                end
`ifdef DEMUX64_COLLECTOR_PARITY_EN
                PARITY: begin
                    if (accept) begin
                        state_d = FULL;
                    end
                end
`endif
                FULL: begin
                    if (bus.out_ready) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // write index; wraps naturally from 63 to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (bus.clear) begin
            idx_q <= '0;
        end else if (fill_acc) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    // word register, only the decoded position is written; others hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (bus.clear) begin
            word_q <= '0;
        end else begin
            for (int k = 0; k < WORD_W; k++) begin
                if (wr_en[k]) begin
                    word_q[k] <= bus.in_bit;
                end
            end
        end
    end

`ifdef DEMUX64_COLLECTOR_PARITY_EN
    logic perr_q;

    // even parity over 64 data bits plus the parity bit; 1 means error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else if (bus.clear) begin
            perr_q <= 1'b0;
        end else if ((state_q == PARITY) && accept) begin
            perr_q <= (^word_q) ^ bus.in_bit;
        end else if (handshake) begin
            perr_q <= 1'b0;
        end
    end

    assign perr_w = perr_q;
`else
    assign perr_w = 1'b0;
`endif

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_word  = word_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_perr  = perr_w;

endmodule

// File: tb/tb_demux64_collector.sv
// tb_demux64_collector: table vectors plus randomized words, all checked
// every cycle against a bit-list model of the collector.
module tb_demux64_collector;

`ifdef DEMUX64_COLLECTOR_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 64 + PAR;

    logic clk;
    logic rst_n;

    demux64_collector_if bus ();

    demux64_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: count of bits taken in this word, the word as a bit
    // array, a full flag and the parity error flag
    logic [63:0] m_word;
    int          m_cnt;
    logic        m_full;
    logic        m_perr;

    typedef struct {
        logic [63:0] data;
        int unsigned vld_pct;
        logic        pbit;
        logic [63:0] exp_word;
        logic        exp_perr_p;
        int          hold;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_word = '0;
        m_cnt  = 0;
        m_full = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic r, input logic c);
        if (c) begin
            model_reset();
        end else if (!m_full && v) begin
            if (m_cnt < 64) m_word[m_cnt] = b;
            else            m_perr = (^m_word) ^ b;
            m_cnt++;
            if (m_cnt == NB) begin
                m_full = 1'b1;
                m_cnt  = 0;
            end
        end else if (m_full && r) begin
            m_full = 1'b0;
            m_perr = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".out_word"},  bus.out_word, m_word);
        chk({tag, ".out_idx"},   64'(bus.out_idx), 64'(m_cnt % 64));
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_full));
        chk({tag, ".in_ready"},  64'(bus.in_ready), 64'(!m_full));
        chk({tag, ".out_perr"},  64'(bus.out_perr), 64'(m_perr));
    endtask

    task automatic cycle(input logic v, input logic b, input logic r, input logic c, input string tag);
        bus.in_valid  = v;
        bus.in_bit    = b;
        bus.out_ready = r;
        bus.clear     = c;
        model_step(v, b, r, c);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // the producer holds each bit until it is accepted
    task automatic send_word(input logic [63:0] data, input int unsigned pct, input logic pbit, input string tag);
        int i;
        int budget;
        logic v;
        logic b;
        logic acc;
        i = 0;
        budget = 0;
        while (i < NB && budget < 5000) begin
            v   = ($urandom_range(99) < pct);
            b   = (i < 64) ? data[i] : pbit;
            acc = v && !m_full;
            cycle(v, b, 1'b0, 1'b0, tag);
            if (acc) i++;
            budget++;
        end
        if (i < NB) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got %0d bits expected %0d", tag, i, NB);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rdata;
        logic        exp_p;

        tbl[0] = '{64'h5555_5555_5555_5555, 100, 1'b0, 64'h5555_5555_5555_5555, 1'b0, 10};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF,  50, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF,  70, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0};
        tbl[3] = '{64'h0123_4567_89AB_CDEF,  80, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 3};

        rst_n         = 1'b0;
        bus.clear     = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // table vectors: fill, hold in FULL with in_valid high, then handshake
        for (int t = 0; t < 4; t++) begin
            send_word(tbl[t].data, tbl[t].vld_pct, tbl[t].pbit, "tbl_fill");
`ifdef DEMUX64_COLLECTOR_PARITY_EN
            exp_p = tbl[t].exp_perr_p;
`else
            exp_p = 1'b0;
`endif
            chk("tbl_word",  bus.out_word, tbl[t].exp_word);
            chk("tbl_valid", 64'(bus.out_valid), 64'd1);
            chk("tbl_perr",  64'(bus.out_perr), 64'(exp_p));
            for (int h = 0; h < tbl[t].hold; h++) begin
                cycle(1'b1, logic'($urandom_range(1)), 1'b0, 1'b0, "tbl_hold");
                chk("tbl_hold_word", bus.out_word, tbl[t].exp_word);
                chk("tbl_hold_idx",  64'(bus.out_idx), 64'd0);
            end
            cycle(1'b0, 1'b0, 1'b1, 1'b0, "tbl_hs");
            chk("tbl_hs_valid", 64'(bus.out_valid), 64'd0);
            chk("tbl_hs_ready", 64'(bus.in_ready), 64'd1);
        end

        // 20 accepts, then clear together with a valid bit
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, "pre_clear");
        chk("pre_clear_idx", 64'(bus.out_idx), 64'd20);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, "clear");
        chk("clear_idx",  64'(bus.out_idx), 64'd0);
        chk("clear_word", bus.out_word, 64'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, "post_clear");

        // clear beats a same-cycle FULL handshake
        send_word(64'hA5A5_0F0F_3C3C_9696, 100, 1'b1, "full_clear_fill");
        cycle(1'b1, 1'b1, 1'b1, 1'b1, "full_clear");
        chk("full_clear_word",  bus.out_word, 64'd0);
        chk("full_clear_valid", 64'(bus.out_valid), 64'd0);

        // randomized words with random consumer back-pressure
        for (int w = 0; w < 5; w++) begin
            rdata = {$urandom, $urandom};
            send_word(rdata, $urandom_range(100, 30), logic'($urandom_range(1)), "rnd_fill");
            chk("rnd_word", bus.out_word, rdata);
            for (int d = 0; d < int'($urandom_range(5)); d++) begin
                cycle(logic'($urandom_range(1)), logic'($urandom_range(1)), 1'b0, 1'b0, "rnd_wait");
            end
            cycle(1'b0, 1'b0, 1'b1, 1'b0, "rnd_hs");
        end

        // asynchronous reset in the middle of a word at index 37
        for (int i = 0; i < 37; i++) cycle(1'b1, logic'($urandom_range(1)), 1'b0, 1'b0, "pre_rst");
        chk("pre_rst_idx", 64'(bus.out_idx), 64'd37);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        chk("async_rst_idx", 64'(bus.out_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
